timing_ctrl: RTL
================

# timing_ctrl

Run/stop/single-step controller for the CPU's beat generator. It produces the one-hot beat phases T1/T2/T3 and the one-hot machine-cycle index M, sequences a variable number of machine cycles per instruction, and inserts wait states on slow memory. It sits between the front-panel/debug controls and the control-unit decoder, which consumes T and M to time register and memory transfers.

## Interface
- MAX_CYC, 4: maximum machine cycles per instruction (width of M, 2..8).
- WAIT_MAX, 15: stall beats tolerated before timeout (only with timeout feature).
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  reset; synchronous, active-high.
- start  in  1  pulse; begin free-running execution.
- stop  in  1  pulse; halt at the next instruction boundary.
- step  in  1  pulse; execute exactly one instruction, then idle.
- ncyc  in  $clog2(MAX_CYC)+1  machine cycles for the current instruction; sampled at T1 of M[0].
- mem_ready  in  1  memory ready; sampled during T2.
- T1, T2, T3  out  1 each  one-hot beat phases; all 0 when idle.
- M  out  MAX_CYC  one-hot machine-cycle index; all 0 when idle.
- running  out  1  high in RUN, STEP, or STALL.
- instr_done  out  1  one-cycle pulse coincident with T3 of the last machine cycle.
- wait_err  out  1  sticky stall-timeout flag.

## Operation
- States: IDLE, RUN, STEP, STALL. All outputs are registered.
- Reset: state IDLE; T1=T2=T3=0, M=0, running=0, instr_done=0, wait_err=0; stop_pending and the latched ncyc are cleared. Reset mid-instruction aborts immediately.
- IDLE: if stop is high, remain in IDLE, even if start or step is also high. Otherwise start → RUN; otherwise step → STEP. Either transition enters the instruction at T1, M[0].
- RUN/STEP beats: T1→T2→T3→T1, one beat per clock.
- Machine cycles: at T3, if the cycle index equals ncyc_lat−1, assert instr_done, set the index to 0, and use M[0] for the next cycle. Otherwise increment the index.
- ncyc latching: ncyc is latched at T1 of M[0]. A value of 0 is treated as 1. Values above MAX_CYC are clamped to MAX_CYC.
- Wait states: in T2 with mem_ready=0, go to STALL. T2 and M are held, and running stays 1. When mem_ready=1, leave STALL and advance to T3 on the next clock, then return to the originating mode (RUN or STEP).
- stop in RUN or STALL: sets stop_pending. On the instr_done beat with stop_pending set, go to IDLE and clear stop_pending. stop in STEP is ignored.
- STEP: after its instr_done beat, go to IDLE.
- Ignored inputs: start in RUN/STEP/STALL, and step outside IDLE.

## Timing
- start/step sampled high in cycle n → T1=1, M[0]=1, running=1 in cycle n+1.
- Instruction length with no stalls: 3×ncyc_lat clocks. Each stall clock adds one.
- Boundary halt: the clock after the instr_done beat has T1=T2=T3=0, M=0, running=0.
- stop on the instr_done beat itself: takes effect at that boundary.
- Exactly one of T1/T2/T3 is high whenever running=1.
- mem_ready is ignored outside T2.

## Configuration
- TIMING_WAIT_TIMEOUT_EN defined:
  - A 4-bit stall counter counts STALL clocks.
  - On reaching WAIT_MAX, set wait_err and force progress to T3 as if mem_ready=1.
  - wait_err clears only on sys_rst.
- TIMING_WAIT_TIMEOUT_EN undefined:
  - STALL persists indefinitely.
  - wait_err is tied to 0 and no counter is built.

## Test plan
- Reset, then start with ncyc=2, mem_ready=1 → T sequence T1,T2,T3,T1,T2,T3; M[0] for 3 clocks then M[1] for 3 clocks; instr_done on clock 6; repeats.
- step with ncyc=3 → exactly 9 running clocks and one instr_done, then IDLE with all outputs 0; a second step runs again.
- RUN with ncyc=1, mem_ready=0 for 4 clocks at T2 → T2 held 5 clocks total, instruction length 7 clocks.
- stop asserted at T2 of M[0] with ncyc=2 → execution completes M[1]; IDLE the clock after instr_done. Simultaneous start+stop in IDLE → stays IDLE.
- With TIMING_WAIT_TIMEOUT_EN and WAIT_MAX=15: mem_ready held 0 → T3 reached after 15 stall clocks and wait_err=1. Without the macro → stays in T2 for 100 clocks and wait_err=0.
- sys_rst asserted in STALL at M[1] → next clock all outputs 0 and state IDLE; start afterwards begins at M[0], T1.

Source files
------------

// File: rtl/timing_ctrl.sv
// timing_ctrl - run/stop/single-step beat generator for the CPU control unit.
//
// Produces the one-hot beat phases T1/T2/T3 and the one-hot machine-cycle
// index M. Each instruction runs a variable number of machine cycles. Wait
// states are inserted while memory is not ready during T2.
//
// Optional feature (compile-time macro TIMING_WAIT_TIMEOUT_EN):
//   defined   - a 4-bit stall counter forces progress after WAIT_MAX stall
//               clocks and sets the sticky wait_err flag. The WAIT_MAX
//               parameter exists only in this build.
//   undefined - a stall lasts until mem_ready rises; wait_err is tied to 0.
//
// Parameters:
//   MAX_CYC   maximum machine cycles per instruction (width of M, 2..8)
//   WAIT_MAX  stall clocks tolerated before timeout (timeout build only)
//
// Ports:
//   sys_clk      clock, rising edge
//   sys_rst      synchronous active-high reset
//   start        pulse: begin free-running execution (IDLE only)
//   stop         pulse: halt at the next instruction boundary
//   step         pulse: execute exactly one instruction (IDLE only)
//   ncyc         machine cycles for this instruction, sampled at T1 of M[0]
//   mem_ready    memory ready, sampled during T2
//   T1, T2, T3   one-hot beat phases, all 0 when idle
//   M            one-hot machine-cycle index, all 0 when idle
//   running      high in RUN, STEP or STALL
//   instr_done   one-clock pulse with T3 of the last machine cycle
//   wait_err     sticky stall-timeout flag
//   dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 STEP, 3 STALL)
module timing_ctrl #(
    parameter int MAX_CYC  = 4
`ifdef TIMING_WAIT_TIMEOUT_EN
    ,
    parameter int WAIT_MAX = 15
`endif
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       step,
    input  logic [$clog2(MAX_CYC):0]   ncyc,
    input  logic                       mem_ready,
    output logic                       T1,
    output logic                       T2,
    output logic                       T3,
    output logic [MAX_CYC-1:0]         M,
    output logic                       running,
    output logic                       instr_done,
    output logic                       wait_err,
    output logic [1:0]                 dbg_state_o
);

    localparam int NW = $clog2(MAX_CYC) + 1;  // width of ncyc / latched count
    localparam int IW = $clog2(MAX_CYC);      // width of the cycle index

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_STALL = 2'd3
    } state_e;

    state_e              state_q, state_d;
    state_e              mode_q, mode_d;      // mode to resume after a stall
    logic [2:0]          t_q, t_d;            // {T3, T2, T1}, one-hot
    logic [IW-1:0]       idx_q, idx_d;
    logic [MAX_CYC-1:0]  m_q, m_d;
    logic                run_q, run_d;
    logic                done_q, done_d;
    logic [NW-1:0]       lat_q, lat_d;
    logic                stop_pend_q, stop_pend_d;
    logic                last_cyc;
    logic                leave_stall;

    // Zero counts as one machine cycle; oversize requests saturate.
    function automatic logic [NW-1:0] clamp_ncyc(input logic [NW-1:0] n);
        if (n == '0)
            return NW'(1);
        else if (n > NW'(MAX_CYC))
            return NW'(MAX_CYC);
        else
            return n;
    endfunction

    assign last_cyc = (NW'(idx_q) == (lat_q - NW'(1)));

`ifdef TIMING_WAIT_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       werr_q, werr_d;
    logic       timeout;

    // cnt_q holds the number of stall clocks already completed, so the
    // WAIT_MAX-th stall clock is the one where cnt_q == WAIT_MAX-1.
    assign timeout     = (state_q == S_STALL) && !mem_ready &&
                         (cnt_q == 4'(WAIT_MAX - 1));
    assign leave_stall = mem_ready || timeout;
    assign wait_err    = werr_q;
`else
    assign leave_stall = mem_ready;
    assign wait_err    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        t_d         = t_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
`ifdef TIMING_WAIT_TIMEOUT_EN
        cnt_d       = cnt_q;
        werr_d      = werr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // stop has priority over a simultaneous start or step.
                if (!stop && (start || step)) begin
                    state_d     = start ? S_RUN : S_STEP;
                    t_d         = 3'b001;
                    idx_d       = '0;
                    stop_pend_d = 1'b0;
                end
            end
            S_RUN, S_STEP: begin
                if (state_q == S_RUN && stop)
                    stop_pend_d = 1'b1;
                if (t_q[0]) begin
                    t_d = 3'b010;
                    if (idx_q == '0)
                        lat_d = clamp_ncyc(ncyc);
                end else if (t_q[1]) begin
                    if (mem_ready) begin
                        t_d    = 3'b100;
                        done_d = last_cyc;
                    end else begin
                        state_d = S_STALL;
                        mode_d  = state_q;
`ifdef TIMING_WAIT_TIMEOUT_EN
                        cnt_d   = 4'd0;
`endif
                    end
                end else if (t_q[2]) begin
                    if (done_q) begin
                        idx_d = '0;
                        // A stop arriving on the done beat itself still halts here.
                        if (state_q == S_STEP || stop_pend_q || stop) begin
                            state_d     = S_IDLE;
                            t_d         = 3'b000;
                            stop_pend_d = 1'b0;
                        end else begin
                            t_d = 3'b001;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        t_d   = 3'b001;
                    end
                end else begin
                    state_d = S_IDLE;
                    t_d     = 3'b000;
                end
            end
            S_STALL: begin
                if (stop)
                    stop_pend_d = 1'b1;
                if (leave_stall) begin
                    state_d = mode_q;
                    t_d     = 3'b100;
                    done_d  = last_cyc;
`ifdef TIMING_WAIT_TIMEOUT_EN
                    if (timeout)
                        werr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                t_d     = 3'b000;
            end
        endcase

        run_d = (state_d != S_IDLE);
        m_d   = run_d ? ({{(MAX_CYC-1){1'b0}}, 1'b1} << idx_d) : '0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            mode_q      <= S_IDLE;
            t_q         <= 3'b000;
            idx_q       <= '0;
            m_q         <= '0;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            lat_q       <= '0;
            stop_pend_q <= 1'b0;
`ifdef TIMING_WAIT_TIMEOUT_EN
            cnt_q       <= 4'd0;
            werr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            t_q         <= t_d;
            idx_q       <= idx_d;
            m_q         <= m_d;
            run_q       <= run_d;
            done_q      <= done_d;
            lat_q       <= lat_d;
            stop_pend_q <= stop_pend_d;
`ifdef TIMING_WAIT_TIMEOUT_EN
            cnt_q       <= cnt_d;
            werr_q      <= werr_d;
`endif
        end
    end

    assign T1          = t_q[0];
    assign T2          = t_q[1];
    assign T3          = t_q[2];
    assign M           = m_q;
    assign running     = run_q;
    assign instr_done  = done_q;
    assign dbg_state_o = state_q;

endmodule
